uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Receive-side frame controller for the UART path. It detects start edges on the serial line and gates the receive baud-rate tick generator on and off. It samples start, data, optional parity and stop bits on the generator's mid-bit pulse. It then presents each assembled byte, with error flags, through a valid/ready interface to the downstream byte consumer.

Parameters:
DATA_BITS, 8, data bits per frame (5..8), LSB first
PARITY_EN, 0, 1 = parity bit follows data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)

Ports:
clk  input  1  system clock, 49.152 MHz
reset  input  1  asynchronous, active-high reset
rxd  input  1  raw serial line, idle high, asynchronous to clk
bps_en  output  1  enable to baud tick generator; generator counter held at 0 while low
bps_clk  input  1  single-cycle mid-bit pulse from generator
rx_data  output  DATA_BITS  received byte
rx_valid  output  1  rx_data/flags valid
rx_ready  input  1  consumer accepts on rx_valid & rx_ready
frame_err  output  1  stop bit sampled 0; qualified by rx_valid
parity_err  output  1  parity mismatch; qualified by rx_valid; 0 when PARITY_EN=0
overrun  output  1  one-cycle pulse: completed frame dropped
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset values: bps_en=0, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, state=IDLE. Reset is legal at any point, including mid-frame; the partial frame is discarded.
- Input conditioning: rxd passes through a 2-flop synchronizer (reset to 1) into rxd_s. A history flop rxd_p (reset to 0) holds the previous rxd_s.
- Start edge: rxd_p==1 && rxd_s==0. A line already low at reset release is ignored until it has been seen high.
- Generator contract: bps_en rises, then the first bps_clk arrives 2560 clk later (half bit), then every 5120 clk (9600 baud). bps_clk is ignored while in IDLE.
- IDLE: on start edge -> START and bps_en=1 (registered, next cycle).
- START: on bps_clk, sample rxd_s.
  - 1 = glitch: -> IDLE, bps_en=0, no output, no flags.
  - 0: bit_cnt=0 -> DATA.
- DATA: on each bps_clk, shift rxd_s into the shift register MSB side (LSB-first line order) and increment bit_cnt. After the DATA_BITS-th sample, -> PARITY if PARITY_EN, else -> STOP.
- PARITY: on bps_clk, capture the parity bit. Mismatch is defined as (XOR of data bits ^ parity bit) != PARITY_ODD. -> STOP.
- STOP: on bps_clk, sample the stop bit, then complete the frame:
  - -> IDLE; bps_en=0 on the next cycle.
  - Output load is attempted in that same cycle.
- Output load:
  - If rx_valid==0, or rx_valid&&rx_ready in that cycle: rx_data, frame_err and parity_err are loaded, and rx_valid=1 from the next cycle.
  - Otherwise the old byte and flags are held, the new frame is discarded, and overrun pulses high for 1 cycle.
- A frame with a framing or parity error is still delivered, with its flag set.
- Latency: rx_valid rises 1 clk after the stop-bit bps_clk, about 9.5 bit times after the start edge for 8N1.
- Handshake:
  - rx_valid, once high, stays high until accepted; rx_data and flags are stable while rx_valid=1.
  - On acceptance with no simultaneous load, rx_valid=0 next cycle.
  - Simultaneous accept and load: rx_valid stays 1 with the new byte.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge half a bit later is caught.
- Break (rxd held low): one frame is delivered as 0x00 with frame_err=1. No further frame is received until rxd returns high and falls again.
- rxd activity while busy does not restart the frame; only bps_clk samples matter.

Test Plan:
- 8N1, send 0xA5 with rx_ready=1 -> after ~48640 clk, rx_data=0xA5, rx_valid=1 for 1 clk, frame_err=0, parity_err=0; bps_en low within 2 clk of completion.
- rxd low pulse of 1000 clk then high -> bps_en pulses high about 2560 clk, returns to 0; rx_valid never asserts; busy=0 afterwards.
- Send 0x3C with stop bit 0 -> rx_data=0x3C, frame_err=1. Hold rxd low 20 bit times -> exactly one extra frame, 0x00 with frame_err=1, then none until rxd rises.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11; overrun pulses once at 0x22 completion. Raise rx_ready -> 0x11 accepted, rx_valid=0.
- PARITY_EN=1, PARITY_ODD=0: send 0x03 + parity 0 -> parity_err=0; send 0x03 + parity 1 -> parity_err=1. With PARITY_ODD=1, the 0x03 + parity 1 frame -> parity_err=0.
- Assert reset during data bit 4 of 0x5A, release, then send 0x81 -> all outputs 0 during reset; only 0x81 is delivered, with no flags.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start-edge detect, baud generator gating,
// mid-bit sampling of start/data/parity/stop, and a one-deep valid/ready output.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic                 bps_en,
  input  logic                 bps_clk,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic       PAR_EN   = (PARITY_EN != 0);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e               state_q, state_d;
  logic                 rxd_m_q, rxd_m_d;
  logic                 rxd_s_q, rxd_s_d;
  logic                 rxd_p_q, rxd_p_d;
  logic                 bps_en_q, bps_en_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;

  logic start_edge, accept, can_load, perr_calc;

  assign start_edge = rxd_p_q & ~rxd_s_q;
  assign accept     = valid_q & rx_ready;
  assign can_load   = ~valid_q | accept;
  assign perr_calc  = PAR_EN & ((^shift_q ^ par_bit_q) != PAR_ODD);

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    rxd_m_d   = rxd;
    rxd_s_d   = rxd_m_q;
    rxd_p_d   = rxd_s_q;
    state_d   = state_q;
    bps_en_d  = bps_en_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    data_d    = data_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    ovr_d     = 1'b0;
    valid_d   = accept ? 1'b0 : valid_q;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d  = START;
          bps_en_d = 1'b1;
        end
      end
      START: begin
        if (bps_clk) begin
          if (rxd_s_q) begin
            state_d  = IDLE;
            bps_en_d = 1'b0;
          end else begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (bps_clk) begin
          shift_d   = {rxd_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) state_d = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bps_clk) begin
          par_bit_d = rxd_s_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
        if (bps_clk) begin
          state_d  = IDLE;
          bps_en_d = 1'b0;
          if (can_load) begin
            data_d  = shift_q;
            ferr_d  = ~rxd_s_q;
            perr_d  = perr_calc;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        bps_en_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_m_q   <= 1'b1;
      rxd_s_q   <= 1'b1;
      rxd_p_q   <= 1'b0;
      state_q   <= IDLE;
      bps_en_q  <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rxd_m_q   <= rxd_m_d;
      rxd_s_q   <= rxd_s_d;
      rxd_p_q   <= rxd_p_d;
      state_q   <= state_d;
      bps_en_q  <= bps_en_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bps_en     = bps_en_q;
  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule
